// File: rtl/conv_layer_sequencer.sv
// Layer sequencer: ifmap column fills, weight-row preloads and commits per pixel.
// Define CONV_SEQ_PERF_CNT_EN to add the stall_cycles performance counter port.
module conv_layer_sequencer #(
  parameter int MAC_NUM = 256,
  parameter int CH_W    = 12,
  parameter int DIM_W   = 9,
  parameter int KMAX    = 5,
  parameter int KS_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CH_W-1:0]    cfg_in_ch,
  input  logic [CH_W-1:0]    cfg_out_ch,
  input  logic [DIM_W-1:0]   cfg_ofm_w,
  input  logic [DIM_W-1:0]   cfg_ofm_h,
  input  logic [KS_W-1:0]    cfg_kernel,
  input  logic               ifmap_valid,
  output logic               ifmap_ready,
  input  logic               weight_valid,
  output logic               bram_transfer_start,
  output logic               load_weight_preload,
  output logic               bram_addr_inc,
  output logic               load_weight,
  output logic [MAC_NUM-1:0] mac_enable,
  output logic               psum_accumulate,
  output logic [CH_W-1:0]    round_idx,
  output logic               busy,
  output logic               layer_done,
  output logic               cfg_err
`ifdef CONV_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  localparam logic [CH_W-1:0]  CH_ONE  = 1;
  localparam logic [DIM_W-1:0] DIM_ONE = 1;
  localparam logic [KS_W-1:0]  KS_ONE  = 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, FILL, WSTART, WROW, WCOMMIT, SHIFT, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    in_ch_q, in_ch_d, out_ch_q, out_ch_d;
  logic [CH_W-1:0]    rounds_q, rounds_d, r_q, r_d, f_q, f_d;
  logic [DIM_W-1:0]   ofm_w_q, ofm_w_d, ofm_h_q, ofm_h_d;
  logic [DIM_W-1:0]   x_q, x_d, y_q, y_d;
  logic [KS_W-1:0]    k_q, k_d, beat_q, beat_d, row_q, row_d;
  logic               cfg_err_q, cfg_err_d, busy_q, busy_d;
  logic               rdy_q, rdy_d, bts_q, bts_d;
  logic               lw_q, lw_d, done_q, done_d, psum_q, psum_d;
  logic [MAC_NUM-1:0] mac_q, mac_d;
  logic [CH_W:0]      rounds_wide;
  logic [CH_W-1:0]    lanes_left;
  logic               illegal;
  logic               accept;

  assign accept = (state_q == IDLE) && start && !abort;

  // Extra bit keeps in_ch + MAC_NUM-1 from wrapping before the divide.
  assign rounds_wide = ({1'b0, cfg_in_ch} + (CH_W+1)'(MAC_NUM - 1))
                       / (CH_W+1)'(MAC_NUM);

  assign illegal = (in_ch_q == '0) || (out_ch_q == '0) ||
                   (ofm_w_q == '0) || (ofm_h_q == '0) ||
                   (k_q == '0) || (32'(k_q) > 32'(KMAX));

  always_comb begin
    state_d   = state_q;
    in_ch_d   = in_ch_q;
    out_ch_d  = out_ch_q;
    ofm_w_d   = ofm_w_q;
    ofm_h_d   = ofm_h_q;
    k_d       = k_q;
    rounds_d  = rounds_q;
    r_d       = r_q;
    f_d       = f_q;
    x_d       = x_q;
    y_d       = y_q;
    beat_d    = beat_q;
    row_d     = row_q;
    cfg_err_d = cfg_err_q;
    unique case (state_q)
      IDLE: if (accept) begin
        in_ch_d   = cfg_in_ch;
        out_ch_d  = cfg_out_ch;
        ofm_w_d   = cfg_ofm_w;
        ofm_h_d   = cfg_ofm_h;
        k_d       = cfg_kernel;
        rounds_d  = CH_W'(rounds_wide);
        cfg_err_d = 1'b0;
        state_d   = CHECK;
      end
      CHECK: begin
        r_d    = '0;
        f_d    = '0;
        x_d    = '0;
        y_d    = '0;
        beat_d = '0;
        row_d  = '0;
        if (illegal) begin
          cfg_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = FILL;
        end
      end
      FILL: if (ifmap_valid) begin
        if (beat_q == k_q - KS_ONE) begin
          beat_d  = '0;
          state_d = WSTART;
        end else begin
          beat_d = beat_q + KS_ONE;
        end
      end
      WSTART: begin
        row_d   = '0;
        state_d = WROW;
      end
      WROW: if (weight_valid) begin
        if (row_q == k_q - KS_ONE) state_d = WCOMMIT;
        else row_d = row_q + KS_ONE;
      end
      WCOMMIT: begin
        row_d = '0;
        if (f_q != out_ch_q - CH_ONE) begin
          f_d     = f_q + CH_ONE;
          state_d = WROW;
        end else begin
          f_d = '0;
          if (x_q != ofm_w_q - DIM_ONE) begin
            x_d     = x_q + DIM_ONE;
            state_d = SHIFT;
          end else if (y_q != ofm_h_q - DIM_ONE) begin
            x_d     = '0;
            y_d     = y_q + DIM_ONE;
            state_d = FILL;
          end else if (r_q != rounds_q - CH_ONE) begin
            x_d     = '0;
            y_d     = '0;
            r_d     = r_q + CH_ONE;
            state_d = FILL;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: if (ifmap_valid) state_d = WSTART;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      cfg_err_d = cfg_err_q;
    end
  end

  // Outputs are decoded from next-state so they line up with state_q.
  assign lanes_left = in_ch_d - CH_W'(r_d * MAC_NUM);

  always_comb begin
    busy_d = (state_d != IDLE) && (state_d != DONE);
    rdy_d  = (state_d == FILL) || (state_d == SHIFT);
    bts_d  = (state_d == WSTART);
    lw_d   = (state_d == WCOMMIT);
    done_d = (state_d == DONE);
    psum_d = (r_d != '0);
    mac_d  = '0;
    for (int i = 0; i < MAC_NUM; i++) begin
      mac_d[i] = 32'(i) < 32'(lanes_left);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ch_q   <= '0;
      out_ch_q  <= '0;
      ofm_w_q   <= '0;
      ofm_h_q   <= '0;
      k_q       <= '0;
      rounds_q  <= '0;
      r_q       <= '0;
      f_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      beat_q    <= '0;
      row_q     <= '0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      bts_q     <= 1'b0;
      lw_q      <= 1'b0;
      done_q    <= 1'b0;
      psum_q    <= 1'b0;
      mac_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_ch_q   <= in_ch_d;
      out_ch_q  <= out_ch_d;
      ofm_w_q   <= ofm_w_d;
      ofm_h_q   <= ofm_h_d;
      k_q       <= k_d;
      rounds_q  <= rounds_d;
      r_q       <= r_d;
      f_q       <= f_d;
      x_q       <= x_d;
      y_q       <= y_d;
      beat_q    <= beat_d;
      row_q     <= row_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      bts_q     <= bts_d;
      lw_q      <= lw_d;
      done_q    <= done_d;
      psum_q    <= psum_d;
      mac_q     <= mac_d;
    end
  end

  assign ifmap_ready         = rdy_q & ~abort;
  assign bram_transfer_start = bts_q & ~abort;
  assign load_weight         = lw_q & ~abort;
  assign layer_done          = done_q;
  assign load_weight_preload = (state_q == WROW) & weight_valid & ~abort;
  assign bram_addr_inc       = load_weight_preload;
  assign busy                = busy_q;
  assign cfg_err             = cfg_err_q;
  assign mac_enable          = mac_q;
  assign psum_accumulate     = psum_q;
  assign round_idx           = r_q;

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if ((((state_q == FILL) || (state_q == SHIFT)) && !ifmap_valid) ||
                 ((state_q == WROW) && !weight_valid)) begin
      if (stall_q != '1) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: per-layer event counts and lane masks.
module tb_conv_layer_sequencer;
  localparam int MAC_NUM = 256;
  localparam int CH_W    = 12;
  localparam int DIM_W   = 9;
  localparam int KS_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [CH_W-1:0]  cfg_in_ch = '0;
  logic [CH_W-1:0]  cfg_out_ch = '0;
  logic [DIM_W-1:0] cfg_ofm_w = '0;
  logic [DIM_W-1:0] cfg_ofm_h = '0;
  logic [KS_W-1:0]  cfg_kernel = '0;
  logic ifmap_valid = 1'b1;
  logic weight_valid = 1'b1;
  logic ifmap_ready, bram_transfer_start, load_weight_preload;
  logic bram_addr_inc, load_weight, psum_accumulate;
  logic busy, layer_done, cfg_err;
  logic [MAC_NUM-1:0] mac_enable;
  logic [CH_W-1:0] round_idx;
`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  conv_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
    .cfg_ofm_w(cfg_ofm_w), .cfg_ofm_h(cfg_ofm_h),
    .cfg_kernel(cfg_kernel),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
    .weight_valid(weight_valid),
    .bram_transfer_start(bram_transfer_start),
    .load_weight_preload(load_weight_preload),
    .bram_addr_inc(bram_addr_inc), .load_weight(load_weight),
    .mac_enable(mac_enable), .psum_accumulate(psum_accumulate),
    .round_idx(round_idx), .busy(busy),
    .layer_done(layer_done), .cfg_err(cfg_err)
`ifdef CONV_SEQ_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    int bts; int pre; int lw; int beats; int lat; bit err;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int n_bts = 0, n_pre = 0, n_lw = 0, n_beat = 0;
  int n_rdy = 0, n_done = 0, n_incbad = 0;
  int b_bts, b_pre, b_lw, b_beat, b_rdy, b_done, b_mac;
  logic [MAC_NUM-1:0] mac_log[$];
  bit psum_log[$];
  int ridx_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_transfer_start) n_bts++;
    if (load_weight_preload) n_pre++;
    if (bram_addr_inc !== load_weight_preload) n_incbad++;
    if (ifmap_ready && ifmap_valid) n_beat++;
    if (ifmap_ready) n_rdy++;
    if (layer_done) n_done++;
    if (load_weight) begin
      n_lw++;
      mac_log.push_back(mac_enable);
      psum_log.push_back(psum_accumulate);
      ridx_log.push_back(int'(round_idx));
    end
  end

  function automatic exp_t model(int ic, int oc, int w, int h, int k);
    exp_t e;
    int rnd, pix;
    e.err = 1'b0;
    if (ic == 0 || oc == 0 || w == 0 || h == 0 || k == 0 || k > 5) begin
      e.bts = 0; e.pre = 0; e.lw = 0; e.beats = 0; e.lat = 2; e.err = 1'b1;
      return e;
    end
    rnd = (ic + MAC_NUM - 1) / MAC_NUM;
    pix = rnd * w * h;
    e.bts = pix;
    e.pre = pix * oc * k;
    e.lw = pix * oc;
    e.beats = rnd * h * (k + w - 1);
    e.lat = 2 + rnd * h * ((k + 1 + oc * (k + 1)) + (w - 1) * (2 + oc * (k + 1)));
    return e;
  endfunction

  task automatic start_layer(input int ic, input int oc, input int w,
                             input int h, input int k);
    @(posedge clk); #1;
    cfg_in_ch = CH_W'(ic);
    cfg_out_ch = CH_W'(oc);
    cfg_ofm_w = DIM_W'(w);
    cfg_ofm_h = DIM_W'(h);
    cfg_kernel = KS_W'(k);
    start = 1'b1;
    sb_q.push_back(model(ic, oc, w, h, k));
    b_bts = n_bts; b_pre = n_pre; b_lw = n_lw; b_beat = n_beat;
    b_rdy = n_rdy; b_done = n_done; b_mac = mac_log.size();
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int lat, output bit to);
    lat = 0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (layer_done) begin
        lat = cyc - c0 + 1;
        to = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, ifmap_ready, bram_transfer_start, load_weight_preload, bram_addr_inc,
         load_weight, psum_accumulate, layer_done, cfg_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 0", {busy, ifmap_ready, bram_transfer_start,
               load_weight_preload, bram_addr_inc, load_weight, psum_accumulate,
               layer_done, cfg_err});
    end
    checks++;
    if (mac_enable !== '0 || round_idx !== '0) begin
      errors++;
      $display("FAIL reset_mac_round got mac=%h round=%0d want 0", mac_enable, round_idx);
    end
`ifdef CONV_SEQ_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall got %0d want 0", stall_cycles);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_small_layer;
    exp_t e;
    int lat, bad;
    bit to;
    int inc0;
    inc0 = n_incbad;
    start_layer(3, 2, 2, 2, 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL small_busy_c1 got %b want 1", busy);
    end
    wait_done(400, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat) begin
      errors++;
      $display("FAIL small_latency got %0d (timeout=%0d) want %0d", lat, to, e.lat);
    end
    checks++;
    if (n_bts - b_bts != e.bts || n_pre - b_pre != e.pre || n_lw - b_lw != e.lw ||
        n_beat - b_beat != e.beats || n_done - b_done != 1) begin
      errors++;
      $display("FAIL small_counts got bts=%0d pre=%0d lw=%0d beats=%0d done=%0d want %0d %0d %0d %0d 1",
               n_bts - b_bts, n_pre - b_pre, n_lw - b_lw, n_beat - b_beat,
               n_done - b_done, e.bts, e.pre, e.lw, e.beats);
    end
    bad = 0;
    for (int i = 0; i < e.lw; i++) begin
      if (b_mac + i >= mac_log.size()) bad++;
      else if (mac_log[b_mac + i] !== 256'h7) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL small_mac_enable got %0d bad commits want 0 (mask 0x7)", bad);
    end
    checks++;
    if (n_incbad != inc0) begin
      errors++;
      $display("FAIL small_addr_inc got %0d mismatches want 0", n_incbad - inc0);
    end
    checks++;
    if (busy !== 1'b0 || cfg_err !== e.err) begin
      errors++;
      $display("FAIL small_done_state got busy=%b err=%b want 0 %b", busy, cfg_err, e.err);
    end
  endtask

  task automatic test_multi_round;
    exp_t e;
    int lat;
    bit to;
    logic [MAC_NUM-1:0] exp_mac[$];
    logic [MAC_NUM-1:0] m;
    exp_mac.push_back('1);
    m = '0;
    for (int i = 0; i < 44; i++) m[i] = 1'b1;
    exp_mac.push_back(m);
    start_layer(300, 1, 1, 1, 1);
    wait_done(200, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat || n_lw - b_lw != 2) begin
      errors++;
      $display("FAIL multi_lat_lw got lat=%0d lw=%0d want %0d 2", lat, n_lw - b_lw, e.lat);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (b_mac + i >= mac_log.size()) begin
        errors++;
        $display("FAIL multi_round%0d got no commit want one", i);
      end else if (mac_log[b_mac + i] !== exp_mac.pop_front() ||
                   psum_log[b_mac + i] !== (i != 0) || ridx_log[b_mac + i] != i) begin
        errors++;
        $display("FAIL multi_round%0d got mac=%h psum=%b idx=%0d want lanes=%0d psum=%0d idx=%0d",
                 i, mac_log[b_mac + i], psum_log[b_mac + i], ridx_log[b_mac + i],
                 (i == 0) ? 256 : 44, i, i);
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int lat, pre_gap;
    bit to, seen;
    weight_valid = 1'b0;
    start_layer(3, 1, 1, 1, 3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bram_transfer_start;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_wstart got none want bram_transfer_start");
    end
    pre_gap = n_pre;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n_pre != pre_gap) begin
      errors++;
      $display("FAIL bp_gap_preload got %0d want 0", n_pre - pre_gap);
    end
    weight_valid = 1'b1;
    wait_done(200, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat + 5 || n_pre - b_pre != e.pre || n_lw - b_lw != e.lw) begin
      errors++;
      $display("FAIL bp_resume got lat=%0d pre=%0d lw=%0d want %0d %0d %0d",
               lat, n_pre - b_pre, n_lw - b_lw, e.lat + 5, e.pre, e.lw);
    end
`ifdef CONV_SEQ_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd5) begin
      errors++;
      $display("FAIL bp_stall_cycles got %0d want 5", stall_cycles);
    end
`endif
  endtask

  task automatic test_illegal;
    exp_t e;
    int lat;
    bit to;
    start_layer(5, 2, 2, 2, 6);
    wait_done(50, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat || cfg_err !== e.err) begin
      errors++;
      $display("FAIL illegal_done got lat=%0d err=%b want %0d %b", lat, cfg_err, e.lat, e.err);
    end
    checks++;
    if (n_rdy != b_rdy || n_bts != b_bts) begin
      errors++;
      $display("FAIL illegal_no_ready got rdy=%0d bts=%0d want 0 0", n_rdy - b_rdy, n_bts - b_bts);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky got %b want 1", cfg_err);
    end
    start_layer(5, 1, 1, 1, 2);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got %b want 0", cfg_err);
    end
    wait_done(200, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat || b_mac >= mac_log.size() || mac_log[b_mac] !== 256'h1f) begin
      errors++;
      $display("FAIL illegal_next_layer got lat=%0d want %0d mask 0x1f", lat, e.lat);
    end
  endtask

  task automatic test_abort;
    exp_t e;
    int lat, d0;
    bit to, seen;
    start_layer(3, 2, 2, 2, 3);
    e = sb_q.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = load_weight_preload;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    #1;
    checks++;
    if (!seen || load_weight_preload !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse got seen=%b preload=%b want 1 0", seen, load_weight_preload);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ifmap_ready !== 1'b0 || load_weight !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b rdy=%b lw=%b want 0 0 0", busy, ifmap_ready, load_weight);
    end
    d0 = n_done;
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (n_done != d0 || n_done != b_done) begin
      errors++;
      $display("FAIL abort_no_done got %0d want 0", n_done - b_done);
    end
    start_layer(3, 2, 2, 2, 3);
    wait_done(400, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat || n_pre - b_pre != e.pre || n_lw - b_lw != e.lw ||
        n_beat - b_beat != e.beats) begin
      errors++;
      $display("FAIL abort_rerun got lat=%0d pre=%0d lw=%0d beats=%0d want %0d %0d %0d %0d",
               lat, n_pre - b_pre, n_lw - b_lw, n_beat - b_beat, e.lat, e.pre, e.lw, e.beats);
    end
  endtask

  task automatic test_reset_mid_fill;
    exp_t e;
    bit seen;
    start_layer(300, 2, 2, 2, 3);
    e = sb_q.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = ifmap_ready;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!seen || {busy, ifmap_ready, bram_transfer_start, load_weight, layer_done,
                  cfg_err, psum_accumulate} !== 7'b0 || mac_enable !== '0 || round_idx !== '0) begin
      errors++;
      $display("FAIL rst_mid_fill got seen=%b busy=%b rdy=%b mac=%h want 1 0 0 0",
               seen, busy, ifmap_ready, mac_enable);
    end
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (n_done != b_done) begin
      errors++;
      $display("FAIL rst_no_done got %0d want 0", n_done - b_done);
    end
  endtask

  task automatic test_start_ignored;
    exp_t e;
    int lat, d1, t1;
    bit to;
    start_layer(3, 2, 2, 2, 3);
    repeat (10) @(posedge clk);
    #1;
    cfg_in_ch = 12'd5; cfg_out_ch = 12'd1;
    cfg_ofm_w = 9'd1; cfg_ofm_h = 9'd1; cfg_kernel = 3'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat != e.lat || n_bts - b_bts != e.bts || n_pre - b_pre != e.pre ||
        n_lw - b_lw != e.lw || n_beat - b_beat != e.beats) begin
      errors++;
      $display("FAIL busy_start_counts got lat=%0d bts=%0d pre=%0d lw=%0d want %0d %0d %0d %0d",
               lat, n_bts - b_bts, n_pre - b_pre, n_lw - b_lw, e.lat, e.bts, e.pre, e.lw);
    end
    d1 = n_done;
    t1 = n_bts;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (n_done != d1 || n_bts != t1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored got done=%0d bts=%0d busy=%b want 0 0 0",
               n_done - d1, n_bts - t1, busy);
    end
  endtask

  initial begin
    test_reset();
    test_small_layer();
    test_multi_round();
    test_backpressure();
    test_illegal();
    test_abort();
    test_reset_mid_fill();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
